// File: rtl/sine_step_ctrl_pkg.sv
// Shared definitions for the sine/cos oscillator sequencer: FSM states,
// waveform constants and the step-counter width check.
package sine_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_WRAP = 2'd3
  } state_e;

  // 2*pi*64 steps complete one waveform with the >>>6 rotation
  localparam int unsigned STEPS_CYC_DEF = 402;

  localparam logic signed [15:0] OSC_SIN_INIT = 16'sd0;
  localparam logic signed [15:0] OSC_COS_INIT = 16'sd30000;
  localparam int unsigned        OSC_SHIFT    = 6;

  function automatic bit step_width_ok(input int unsigned w, input int unsigned steps);
    return (64'd1 << w) >= 64'(steps);
  endfunction

endpackage

// File: rtl/sine_step_ctrl_prescaler.sv
// Clock prescaler: counts 0..div and flags the terminal count; the counter
// restarts on tc so it never exceeds div.
module step_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tc_o,
  output logic [DIV_W-1:0] pre_cnt_o
);

  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tc_o      = (pre_cnt_q == div_i);
  assign pre_cnt_o = pre_cnt_q;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear_i) begin
      pre_cnt_d = '0;
    end else if (enable_i) begin
      pre_cnt_d = tc_o ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/sine_step_ctrl.sv
// Sequencer for the sine/cos oscillator: one-cycle load, prescaled step
// enables, per-waveform step counting and optional re-seed at each wrap.
module sine_step_ctrl
  import sine_step_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned STEP_W    = 10,
  parameter int unsigned STEPS_CYC = STEPS_CYC_DEF,
  parameter int unsigned DEF_DIV   = 0,
  parameter int unsigned RESYNC    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              osc_load,
  output logic              osc_step,
  output logic              cycle_done,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy
);

  if (!step_width_ok(STEP_W, STEPS_CYC)) begin : g_step_w_check
    $error("STEP_W too narrow for STEPS_CYC");
  end

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  pre_cnt;
  logic              tc;
  logic              in_run;
  logic              last_step;

  // run has priority over tc: a dropped run suppresses the step that cycle
  assign in_run    = (state_q == ST_RUN) && run;
  assign last_step = (step_cnt_q == STEP_W'(STEPS_CYC - 1));

  step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!in_run),
    .enable_i  (in_run),
    .div_i     (div_q),
    .tc_o      (tc),
    .pre_cnt_o (pre_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_LOAD;
      ST_LOAD: state_d = run ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tc && last_step && (RESYNC != 0)) begin
          state_d = ST_WRAP;
        end
      end
      ST_WRAP: state_d = run ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    osc_load   = (state_q == ST_LOAD) || (state_q == ST_WRAP);
    osc_step   = in_run && tc;
    cycle_done = in_run && tc && last_step;
    cfg_ready  = (state_q == ST_IDLE) || ((state_q == ST_RUN) && tc);
    busy       = (state_q != ST_IDLE);
  end

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (!run || (state_q == ST_IDLE) || (state_q == ST_LOAD)) begin
      step_cnt_d = '0;
    end else if (in_run && tc) begin
      step_cnt_d = last_step ? '0 : step_cnt_q + 1'b1;
    end
  end

  // acceptance is independent of run so a div offered as run drops is kept
  always_comb begin
    div_d = div_q;
    if (cfg_valid && cfg_ready) begin
      div_d = cfg_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
      div_q      <= DIV_W'(DEF_DIV);
    end else begin
      step_cnt_q <= step_cnt_d;
      div_q      <= div_d;
    end
  end

  assign step_cnt = step_cnt_q;

  a_pre_bound: assert property (@(posedge clk) disable iff (rst) pre_cnt <= div_q);

endmodule

// File: tb/tb_sine_step_ctrl.sv
// Directed bench for sine_step_ctrl: reset, step timing, config handshake,
// run drop, mid-run reset, free-run mode and oscillator amplitude stability.
module tb_sine_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, osc_load, osc_step, cycle_done, busy;
  logic [9:0] step_cnt;

  logic       rst2, run2, cfg_valid2;
  logic [7:0] cfg_div2;
  logic       cfg_ready2, osc_load2, osc_step2, cycle_done2, busy2;
  logic [9:0] step_cnt2;

  int unsigned passed = 0;
  int unsigned total  = 0;

  sine_step_ctrl #(
    .DIV_W(8), .STEP_W(10), .STEPS_CYC(402), .DEF_DIV(0), .RESYNC(1)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .osc_load(osc_load), .osc_step(osc_step),
    .cycle_done(cycle_done), .step_cnt(step_cnt), .busy(busy)
  );

  sine_step_ctrl #(
    .DIV_W(8), .STEP_W(10), .STEPS_CYC(402), .DEF_DIV(0), .RESYNC(0)
  ) dut_fr (
    .clk(clk), .rst(rst2), .run(run2), .cfg_valid(cfg_valid2), .cfg_div(cfg_div2),
    .cfg_ready(cfg_ready2), .osc_load(osc_load2), .osc_step(osc_step2),
    .cycle_done(cycle_done2), .step_cnt(step_cnt2), .busy(busy2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    cyc(); cyc();
    #1;
    total++;
    if ({osc_load, osc_step, cycle_done, busy, cfg_ready} !== 5'b00001)
      $display("FAIL reset_flags: got %b want 00001", {osc_load, osc_step, cycle_done, busy, cfg_ready});
    else passed++;
    total++;
    if (step_cnt !== 10'd0) $display("FAIL reset_step_cnt: got %0d want 0", step_cnt);
    else passed++;
  endtask

  task automatic test_div0_cycle();
    rst = 1'b0; run = 1'b1;
    cyc();
    #1;
    total++;
    if ({osc_load, osc_step, cycle_done, busy, cfg_ready} !== 5'b10010)
      $display("FAIL div0_load: got %b want 10010", {osc_load, osc_step, cycle_done, busy, cfg_ready});
    else passed++;
    for (int i = 0; i < 402; i++) begin
      cyc();
      #1;
      total++;
      if ({osc_load, osc_step, cycle_done} !== {1'b0, 1'b1, (i == 401)} || step_cnt !== 10'(i))
        $display("FAIL div0_step%0d: got ld/st/dn=%b cnt=%0d want %b cnt=%0d",
                 i, {osc_load, osc_step, cycle_done}, step_cnt, {1'b0, 1'b1, (i == 401)}, i);
      else passed++;
    end
    cyc();
    #1;
    total++;
    if ({osc_load, osc_step, cycle_done, busy, cfg_ready} !== 5'b10010 || step_cnt !== 10'd0)
      $display("FAIL div0_wrap: got %b cnt=%0d want 10010 cnt=0",
               {osc_load, osc_step, cycle_done, busy, cfg_ready}, step_cnt);
    else passed++;
    cyc();
    #1;
    total++;
    if ({osc_load, osc_step} !== 2'b01 || step_cnt !== 10'd0)
      $display("FAIL div0_after_wrap: got %b cnt=%0d want 01 cnt=0", {osc_load, osc_step}, step_cnt);
    else passed++;
    run = 1'b0;
    #1;
    total++;
    if (osc_step !== 1'b0) $display("FAIL div0_run_drop_step: got %b want 0", osc_step);
    else passed++;
    cyc();
    #1;
    total++;
    if (busy !== 1'b0 || step_cnt !== 10'd0)
      $display("FAIL div0_idle: got busy=%b cnt=%0d want busy=0 cnt=0", busy, step_cnt);
    else passed++;
  endtask

  task automatic test_cfg_handshake();
    int exp_cnt [2:13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3};
    logic exp_tc;
    cfg_valid = 1'b1; cfg_div = 8'd3; run = 1'b1;
    #1;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL cfg_idle_ready: got %b want 1", cfg_ready);
    else passed++;
    cyc();
    cfg_valid = 1'b0;
    #1;
    total++;
    if ({osc_load, cfg_ready} !== 2'b10) $display("FAIL cfg_load: got %b want 10", {osc_load, cfg_ready});
    else passed++;
    for (int c = 2; c <= 13; c++) begin
      cyc();
      if (c == 6) begin cfg_valid = 1'b1; cfg_div = 8'd1; end
      if (c == 10) cfg_valid = 1'b0;
      #1;
      exp_tc = (c == 5) || (c == 9) || (c == 11) || (c == 13);
      total++;
      if ({osc_step, cfg_ready} !== {exp_tc, exp_tc} || step_cnt !== 10'(exp_cnt[c]))
        $display("FAIL cfg_cycle%0d: got step/ready=%b cnt=%0d want %b cnt=%0d",
                 c, {osc_step, cfg_ready}, step_cnt, {exp_tc, exp_tc}, exp_cnt[c]);
      else passed++;
    end
    run = 1'b0;
    cyc();
  endtask

  task automatic test_run_drop_last();
    cfg_valid = 1'b1; cfg_div = 8'd0; run = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    repeat (402) cyc();
    run = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd2;
    #1;
    total++;
    if (step_cnt !== 10'd401 || {osc_step, cycle_done, cfg_ready} !== 3'b001)
      $display("FAIL drop_last: got cnt=%0d st/dn/rdy=%b want cnt=401 001",
               step_cnt, {osc_step, cycle_done, cfg_ready});
    else passed++;
    cyc();
    cfg_valid = 1'b0;
    #1;
    total++;
    if ({busy, osc_load} !== 2'b00 || step_cnt !== 10'd0)
      $display("FAIL drop_idle: got busy/ld=%b cnt=%0d want 00 cnt=0", {busy, osc_load}, step_cnt);
    else passed++;
  endtask

  task automatic test_mid_reset();
    run = 1'b1;
    cyc();
    for (int c = 2; c <= 4; c++) begin
      cyc();
      #1;
      total++;
      if (osc_step !== (c == 4)) $display("FAIL kept_div_c%0d: got %b want %b", c, osc_step, (c == 4));
      else passed++;
    end
    for (int k = 0; k < 1000 && step_cnt != 10'd100; k++) cyc();
    total++;
    if (step_cnt !== 10'd100 || busy !== 1'b1)
      $display("FAIL mid_reach100: got cnt=%0d busy=%b want cnt=100 busy=1", step_cnt, busy);
    else passed++;
    rst = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd7;
    cyc();
    #1;
    total++;
    if ({osc_load, osc_step, cycle_done, busy, cfg_ready} !== 5'b00001 || step_cnt !== 10'd0)
      $display("FAIL mid_reset: got %b cnt=%0d want 00001 cnt=0",
               {osc_load, osc_step, cycle_done, busy, cfg_ready}, step_cnt);
    else passed++;
    rst = 1'b0; cfg_valid = 1'b0;
    cyc();
    cyc();
    #1;
    total++;
    if (osc_step !== 1'b1) $display("FAIL mid_def_div: got %b want 1", osc_step);
    else passed++;
    run = 1'b0;
    cyc();
  endtask

  task automatic test_free_run();
    int unsigned loads = 0, dones = 0, steps = 0, load_at = 0;
    int unsigned done_at [2] = '{0, 0};
    rst2 = 1'b0; run2 = 1'b1;
    for (int n = 1; n <= 810; n++) begin
      cyc();
      #1;
      if (osc_load2) begin loads++; load_at = n; end
      if (osc_step2) steps++;
      if (cycle_done2) begin
        if (dones < 2) done_at[dones] = n;
        dones++;
      end
    end
    total++;
    if (loads !== 1 || load_at !== 1)
      $display("FAIL fr_loads: got %0d at %0d want 1 at 1", loads, load_at);
    else passed++;
    total++;
    if (dones !== 2) $display("FAIL fr_done_count: got %0d want 2", dones);
    else passed++;
    total++;
    if (done_at[0] !== 403 || done_at[1] !== 805)
      $display("FAIL fr_done_cycles: got %0d,%0d want 403,805", done_at[0], done_at[1]);
    else passed++;
    total++;
    if (steps !== 809 || busy2 !== 1'b1)
      $display("FAIL fr_steps: got %0d busy=%b want 809 busy=1", steps, busy2);
    else passed++;
    run2 = 1'b0;
  endtask

  task automatic test_osc_integration();
    int s = 0, c = 0, idx = 0;
    int pk [4] = '{-1000, -1000, -1000, -1000};
    run = 1'b1;
    for (int k = 0; k < 3000 && idx < 4; k++) begin
      cyc();
      #1;
      if (osc_load) begin s = 0; c = 30000; end
      if (osc_step) begin
        s = s + (c >>> 6);
        c = c - (s >>> 6);
      end
      if ((s >>> 8) > pk[idx]) pk[idx] = s >>> 8;
      if (cycle_done) idx++;
    end
    total++;
    if (idx !== 4) $display("FAIL osc_cycles: got %0d want 4", idx);
    else passed++;
    total++;
    if (pk[0] < 116 || pk[0] > 118) $display("FAIL osc_peak0: got %0d want 116..118", pk[0]);
    else passed++;
    for (int j = 1; j < 4; j++) begin
      total++;
      if (pk[j] > pk[0] + 1 || pk[j] < pk[0] - 1)
        $display("FAIL osc_peak%0d: got %0d want %0d+/-1", j, pk[j], pk[0]);
      else passed++;
    end
    run = 1'b0;
    cyc();
  endtask

  initial begin
    rst2 = 1'b1; run2 = 1'b0; cfg_valid2 = 1'b0; cfg_div2 = 8'd0;
    test_reset();
    test_div0_cycle();
    test_cfg_handshake();
    test_run_drop_last();
    test_mid_reset();
    test_free_run();
    test_osc_integration();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
